// File: rtl/tage_folded_history.sv
// Folded (XOR-compressed) copy of the newest HL global-history bits, with a
// registered tagged-table index and a chunked rebuild path after history repair.
module tage_folded_history #(
  parameter int unsigned GHL = 8,
  parameter int unsigned HL  = 8,
  parameter int unsigned FL  = 4,
  parameter int unsigned PCW = 8
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic [GHL-1:0] ghr_in,
  input  logic           update,
  input  logic           branchValue,
  input  logic           resync,
  input  logic [PCW-1:0] pc,
  input  logic           pc_valid,
  output logic [FL-1:0]  fold,
  output logic           fold_valid,
  output logic [FL-1:0]  index,
  output logic           index_valid
);

  localparam int unsigned NCH = (HL + FL - 1) / FL;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned INS = HL % FL;

  localparam logic [0:0] TRACK  = 1'b0;
  localparam logic [0:0] RESYNC = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    j_q, j_d;
  logic [FL-1:0]    acc_q, acc_d;
  logic [FL-1:0]    fold_q, fold_d;
  logic [FL-1:0]    index_q, index_d;
  logic             fv_q, fv_d;
  logic             iv_q, iv_d;

  logic [NCH*FL-1:0] hpad;
  logic [FL-1:0]     chunk;
  logic [FL-1:0]     fold_shift;
  logic              last_chunk;

  // Newest-first history window, zero-padded so every chunk is FL bits wide.
  always_comb begin
    hpad = '0;
    for (int unsigned i = 0; i < HL; i++) hpad[i] = ghr_in[GHL-1-i];
    chunk = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (j_q == CW'(c)) chunk = hpad[c*FL +: FL];
    end
  end

  assign last_chunk = (j_q == CW'(NCH - 1));

  // Rotate, retire the outgoing bit at its folded position, insert the new bit.
  always_comb begin
    fold_shift      = {fold_q[FL-2:0], fold_q[FL-1]};
    fold_shift[INS] = fold_shift[INS] ^ ghr_in[GHL-HL];
    fold_shift[0]   = fold_shift[0] ^ branchValue;
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    acc_d   = acc_q;
    fold_d  = fold_q;
    fv_d    = fv_q;
    index_d = index_q;
    iv_d    = 1'b0;

    if (pc_valid && fv_q) begin
      index_d = fold_q ^ pc[FL-1:0] ^ pc[2*FL-1:FL];
      iv_d    = 1'b1;
    end

    if (resync) begin
      state_d = RESYNC;
      acc_d   = '0;
      j_d     = '0;
      fv_d    = 1'b0;
    end else begin
      case (state_q)
        TRACK: begin
          if (update) fold_d = fold_shift;
        end
        RESYNC: begin
          if (update) begin
            // GHR moved under the rebuild: start over on the new contents.
            acc_d = '0;
            j_d   = '0;
          end else if (last_chunk) begin
            fold_d  = acc_q ^ chunk;
            fv_d    = 1'b1;
            state_d = TRACK;
            acc_d   = '0;
            j_d     = '0;
          end else begin
            acc_d = acc_q ^ chunk;
            j_d   = j_q + CW'(1);
          end
        end
        default: state_d = TRACK;
      endcase
    end
  end

  always_ff @(negedge Clk) begin
    if (Rst) begin
      state_q <= TRACK;
      j_q     <= '0;
      acc_q   <= '0;
      fold_q  <= '0;
      fv_q    <= 1'b1;
      index_q <= '0;
      iv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      fold_q  <= fold_d;
      fv_q    <= fv_d;
      index_q <= index_d;
      iv_q    <= iv_d;
    end
  end

  assign fold        = fold_q;
  assign fold_valid  = fv_q;
  assign index       = index_q;
  assign index_valid = iv_q;

endmodule
